// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the piso_tx_ctrl serializer.
// The PARITY state is only reachable when PISO_TX_PARITY_EN is defined.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Bit-counter width; it must be able to hold WIDTH-1.
  function automatic int piso_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-load, MSB-first left shifter with zero fill.
// Load takes priority over shift.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr_p0;

  always_ff @(posedge clk) begin
    if (load) begin
      sr_p0 <= din;
    end else if (shift) begin
      sr_p0 <= {sr_p0[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr_p0[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Two-requester round-robin serializer: grants one word, sends it MSB-first.
// Define PISO_TX_PARITY_EN to append an even-parity bit after each frame.
module piso_tx_ctrl
  import piso_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             ser_src,
  output logic             busy
);

  localparam int CW = piso_cnt_w(WIDTH);

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             ptr;
  logic             grant;
  logic             accept;
  logic             last_d;
  logic [WIDTH-1:0] win;
  logic [WIDTH-1:0] sr_din;
  logic             sr_load;
  logic             sr_shift;
`ifdef PISO_TX_PARITY_EN
  logic             par_q;
`endif

  // Contention goes to ptr; a lone requester wins regardless of ptr.
  always_comb begin
    grant = REQ0;
    if (req0_valid && req1_valid) begin
      grant = ptr;
    end else if (req1_valid) begin
      grant = REQ1;
    end
  end

  assign req0_ready = (state == IDLE) && !rst && (grant == REQ0) && req0_valid;
  assign req1_ready = (state == IDLE) && !rst && (grant == REQ1) && req1_valid;
  assign accept     = req0_ready || req1_ready;
  assign win        = (grant == REQ1) ? req1_data : req0_data;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = win;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = CW'(WIDTH - 1);
          sr_load = 1'b1;
        end
      end
      SHIFT: begin
        sr_shift = 1'b1;
        cnt_d    = cnt - CW'(1);
        if (cnt == '0) begin
`ifdef PISO_TX_PARITY_EN
          // Reuse the drained shifter to present the parity bit as its MSB.
          state_d = PARITY;
          sr_load = 1'b1;
          sr_din  = {par_q, {(WIDTH-1){1'b0}}};
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    // Clearing the shifter on reset keeps ser_out at 0 without gating it.
    if (rst) begin
      sr_load  = 1'b1;
      sr_shift = 1'b0;
      sr_din   = '0;
    end
`ifdef PISO_TX_PARITY_EN
    last_d = (state_d == PARITY);
`else
    last_d = (state_d == SHIFT) && (cnt_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= REQ0;
      ser_src   <= REQ0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ser_valid <= (state_d != IDLE);
      busy      <= (state_d != IDLE);
      ser_last  <= last_d;
      if (accept) begin
        ptr     <= ~grant;
        ser_src <= grant;
      end
    end
  end

`ifdef PISO_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (accept) begin
      par_q <= ^win;
    end
  end
`endif

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk  (clk),
    .load (sr_load),
    .shift(sr_shift),
    .din  (sr_din),
    .msb  (ser_out)
  );

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Self-checking bench for piso_tx_ctrl (WIDTH = 8), table vectors plus scoreboard.
// Follows PISO_TX_PARITY_EN the same way the design does.
`timescale 1ns/1ps
module tb_piso_tx_ctrl;

  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = W + 1 + P;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_data = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_data = '0;
  logic         req1_ready;
  logic         ser_out, ser_valid, ser_last, ser_src, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic b;
    logic last;
    logic src;
  } sbit_t;

  sbit_t sb[$];
  int    acc_cyc[$];
  int    acc_src[$];

  typedef struct {
    logic         v0;
    logic         v1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         r0;
    logic         r1;
  } vec_t;

  vec_t tbl[11];

  piso_tx_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .ser_src   (ser_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic src, input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) begin
      sb.push_back('{b: d[i], last: (i == 0) && (P == 0), src: src});
    end
    if (P == 1) begin
      sb.push_back('{b: ^d, last: 1'b1, src: src});
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) sb.delete();
  end

  // Scoreboard: frames are queued at acceptance and consumed bit by bit.
  always @(negedge clk) begin
    if (mon_en) begin
      sbit_t e;
      if (ser_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ser_out", ser_out, e.b);
          chk("ser_last", ser_last, e.last);
          chk("ser_src", ser_src, e.src);
          chk("busy_frame", busy, 1);
        end
      end else begin
        chk("idle_last", ser_last, 0);
        chk("idle_busy", busy, 0);
      end
      chk("ready_excl", req0_ready & req1_ready, 0);
      if (req0_ready && req0_valid) begin
        acc_cyc.push_back(cyc);
        acc_src.push_back(0);
        push_frame(1'b0, req0_data);
      end
      if (req1_ready && req1_valid) begin
        acc_cyc.push_back(cyc);
        acc_src.push_back(1);
        push_frame(1'b1, req1_data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * FRAME && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 8'h81, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0};

    // Reset hold with a pending request
    rst = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_outputs", {ser_out, ser_valid, ser_last, ser_src, busy}, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    req0_valid = 1'b0;
    mon_en = 1'b1;

    // Table vectors, back to back from ptr = 0
    foreach (tbl[i]) begin
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      req0_data  = tbl[i].d0;
      req1_data  = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d_ready0", i), req0_ready, tbl[i].r0);
      chk($sformatf("vec%0d_ready1", i), req1_ready, tbl[i].r1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (tbl[i].r0 || tbl[i].r1) begin
        repeat (W + P) @(posedge clk);
        #1;
      end
    end
    drain();

    // Single word held valid: ready returns after exactly one bubble
    do_reset();
    acc_cyc.delete();
    acc_src.delete();
    req0_valid = 1'b1;
    req0_data = 8'hA5;
    repeat (FRAME + 1) @(posedge clk);
    #1 req0_valid = 1'b0;
    drain();
    chk("single_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) chk("single_gap", acc_cyc[1] - acc_cyc[0], FRAME);

    // Contention: alternating grants separated by one idle cycle
    do_reset();
    acc_cyc.delete();
    acc_src.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 8'h0F;
    req1_data = 8'hF0;
    repeat (4 * FRAME) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    chk("cont_accepts", acc_cyc.size(), 4);
    for (int i = 0; i < acc_src.size(); i++) begin
      chk($sformatf("cont_grant%0d", i), acc_src[i], i % 2);
      if (i > 0) chk($sformatf("cont_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], FRAME);
    end

    // Single-requester bypass right after reset
    do_reset();
    req1_valid = 1'b1;
    req1_data = 8'h81;
    @(negedge clk);
    chk("bypass_ready1", req1_ready, 1);
    chk("bypass_ready0", req0_ready, 0);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    drain();

    // Mid-frame reset after a req0 grant moved ptr to 1
    do_reset();
    req0_valid = 1'b1;
    req0_data = 8'hA5;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", ser_valid, 0);
    chk("midrst_last", ser_last, 0);
    chk("midrst_out", ser_out, 0);
    chk("midrst_src", ser_src, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 8'h11;
    req1_data = 8'h22;
    @(negedge clk);
    chk("midrst_grant0", req0_ready, 1);
    chk("midrst_nogrant1", req1_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
